// File: rtl/inv_sub_bytes.sv
// ---------------------------------------------------------------------------
// inv_sub_bytes
//   AES-128 InvSubBytes stage for the decryption round datapath. All 16
//   bytes of the 128-bit state pass through the FIPS-197 inverse S-box in
//   parallel and the result is registered (one-cycle latency, one block per
//   cycle throughput).
//
// Ports
//   clk          : system clock, rising edge
//   n_rst        : asynchronous active-low reset
//   in_valid     : qualifies input_block for capture this cycle
//   input_block  : state in; byte k = bits [8k+7:8k]
//   subbed_block : registered result; byte k = InvS(input byte k)
//   out_valid    : high in the cycle after a qualified capture
// ---------------------------------------------------------------------------
module inv_sub_bytes (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         in_valid,
  input  logic [127:0] input_block,
  output logic [127:0] subbed_block,
  output logic         out_valid
);

  // Inverse S-box as a flat 256-entry lookup.
  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    logic [7:0] y;
    y = 8'h00;
    case (x)
      8'h00: y = 8'h52; 8'h01: y = 8'h09; 8'h02: y = 8'h6a; 8'h03: y = 8'hd5; 8'h04: y = 8'h30; 8'h05: y = 8'h36; 8'h06: y = 8'ha5; 8'h07: y = 8'h38;
      8'h08: y = 8'hbf; 8'h09: y = 8'h40; 8'h0a: y = 8'ha3; 8'h0b: y = 8'h9e; 8'h0c: y = 8'h81; 8'h0d: y = 8'hf3; 8'h0e: y = 8'hd7; 8'h0f: y = 8'hfb;
      8'h10: y = 8'h7c; 8'h11: y = 8'he3; 8'h12: y = 8'h39; 8'h13: y = 8'h82; 8'h14: y = 8'h9b; 8'h15: y = 8'h2f; 8'h16: y = 8'hff; 8'h17: y = 8'h87;
      8'h18: y = 8'h34; 8'h19: y = 8'h8e; 8'h1a: y = 8'h43; 8'h1b: y = 8'h44; 8'h1c: y = 8'hc4; 8'h1d: y = 8'hde; 8'h1e: y = 8'he9; 8'h1f: y = 8'hcb;
      8'h20: y = 8'h54; 8'h21: y = 8'h7b; 8'h22: y = 8'h94; 8'h23: y = 8'h32; 8'h24: y = 8'ha6; 8'h25: y = 8'hc2; 8'h26: y = 8'h23; 8'h27: y = 8'h3d;
      8'h28: y = 8'hee; 8'h29: y = 8'h4c; 8'h2a: y = 8'h95; 8'h2b: y = 8'h0b; 8'h2c: y = 8'h42; 8'h2d: y = 8'hfa; 8'h2e: y = 8'hc3; 8'h2f: y = 8'h4e;
      8'h30: y = 8'h08; 8'h31: y = 8'h2e; 8'h32: y = 8'ha1; 8'h33: y = 8'h66; 8'h34: y = 8'h28; 8'h35: y = 8'hd9; 8'h36: y = 8'h24; 8'h37: y = 8'hb2;
      8'h38: y = 8'h76; 8'h39: y = 8'h5b; 8'h3a: y = 8'ha2; 8'h3b: y = 8'h49; 8'h3c: y = 8'h6d; 8'h3d: y = 8'h8b; 8'h3e: y = 8'hd1; 8'h3f: y = 8'h25;
      8'h40: y = 8'h72; 8'h41: y = 8'hf8; 8'h42: y = 8'hf6; 8'h43: y = 8'h64; 8'h44: y = 8'h86; 8'h45: y = 8'h68; 8'h46: y = 8'h98; 8'h47: y = 8'h16;
      8'h48: y = 8'hd4; 8'h49: y = 8'ha4; 8'h4a: y = 8'h5c; 8'h4b: y = 8'hcc; 8'h4c: y = 8'h5d; 8'h4d: y = 8'h65; 8'h4e: y = 8'hb6; 8'h4f: y = 8'h92;
      8'h50: y = 8'h6c; 8'h51: y = 8'h70; 8'h52: y = 8'h48; 8'h53: y = 8'h50; 8'h54: y = 8'hfd; 8'h55: y = 8'hed; 8'h56: y = 8'hb9; 8'h57: y = 8'hda;
      8'h58: y = 8'h5e; 8'h59: y = 8'h15; 8'h5a: y = 8'h46; 8'h5b: y = 8'h57; 8'h5c: y = 8'ha7; 8'h5d: y = 8'h8d; 8'h5e: y = 8'h9d; 8'h5f: y = 8'h84;
      8'h60: y = 8'h90; 8'h61: y = 8'hd8; 8'h62: y = 8'hab; 8'h63: y = 8'h00; 8'h64: y = 8'h8c; 8'h65: y = 8'hbc; 8'h66: y = 8'hd3; 8'h67: y = 8'h0a;
      8'h68: y = 8'hf7; 8'h69: y = 8'he4; 8'h6a: y = 8'h58; 8'h6b: y = 8'h05; 8'h6c: y = 8'hb8; 8'h6d: y = 8'hb3; 8'h6e: y = 8'h45; 8'h6f: y = 8'h06;
      8'h70: y = 8'hd0; 8'h71: y = 8'h2c; 8'h72: y = 8'h1e; 8'h73: y = 8'h8f; 8'h74: y = 8'hca; 8'h75: y = 8'h3f; 8'h76: y = 8'h0f; 8'h77: y = 8'h02;
      8'h78: y = 8'hc1; 8'h79: y = 8'haf; 8'h7a: y = 8'hbd; 8'h7b: y = 8'h03; 8'h7c: y = 8'h01; 8'h7d: y = 8'h13; 8'h7e: y = 8'h8a; 8'h7f: y = 8'h6b;
      8'h80: y = 8'h3a; 8'h81: y = 8'h91; 8'h82: y = 8'h11; 8'h83: y = 8'h41; 8'h84: y = 8'h4f; 8'h85: y = 8'h67; 8'h86: y = 8'hdc; 8'h87: y = 8'hea;
      8'h88: y = 8'h97; 8'h89: y = 8'hf2; 8'h8a: y = 8'hcf; 8'h8b: y = 8'hce; 8'h8c: y = 8'hf0; 8'h8d: y = 8'hb4; 8'h8e: y = 8'he6; 8'h8f: y = 8'h73;
      8'h90: y = 8'h96; 8'h91: y = 8'hac; 8'h92: y = 8'h74; 8'h93: y = 8'h22; 8'h94: y = 8'he7; 8'h95: y = 8'had; 8'h96: y = 8'h35; 8'h97: y = 8'h85;
      8'h98: y = 8'he2; 8'h99: y = 8'hf9; 8'h9a: y = 8'h37; 8'h9b: y = 8'he8; 8'h9c: y = 8'h1c; 8'h9d: y = 8'h75; 8'h9e: y = 8'hdf; 8'h9f: y = 8'h6e;
      8'ha0: y = 8'h47; 8'ha1: y = 8'hf1; 8'ha2: y = 8'h1a; 8'ha3: y = 8'h71; 8'ha4: y = 8'h1d; 8'ha5: y = 8'h29; 8'ha6: y = 8'hc5; 8'ha7: y = 8'h89;
      8'ha8: y = 8'h6f; 8'ha9: y = 8'hb7; 8'haa: y = 8'h62; 8'hab: y = 8'h0e; 8'hac: y = 8'haa; 8'had: y = 8'h18; 8'hae: y = 8'hbe; 8'haf: y = 8'h1b;
      8'hb0: y = 8'hfc; 8'hb1: y = 8'h56; 8'hb2: y = 8'h3e; 8'hb3: y = 8'h4b; 8'hb4: y = 8'hc6; 8'hb5: y = 8'hd2; 8'hb6: y = 8'h79; 8'hb7: y = 8'h20;
      8'hb8: y = 8'h9a; 8'hb9: y = 8'hdb; 8'hba: y = 8'hc0; 8'hbb: y = 8'hfe; 8'hbc: y = 8'h78; 8'hbd: y = 8'hcd; 8'hbe: y = 8'h5a; 8'hbf: y = 8'hf4;
      8'hc0: y = 8'h1f; 8'hc1: y = 8'hdd; 8'hc2: y = 8'ha8; 8'hc3: y = 8'h33; 8'hc4: y = 8'h88; 8'hc5: y = 8'h07; 8'hc6: y = 8'hc7; 8'hc7: y = 8'h31;
      8'hc8: y = 8'hb1; 8'hc9: y = 8'h12; 8'hca: y = 8'h10; 8'hcb: y = 8'h59; 8'hcc: y = 8'h27; 8'hcd: y = 8'h80; 8'hce: y = 8'hec; 8'hcf: y = 8'h5f;
      8'hd0: y = 8'h60; 8'hd1: y = 8'h51; 8'hd2: y = 8'h7f; 8'hd3: y = 8'ha9; 8'hd4: y = 8'h19; 8'hd5: y = 8'hb5; 8'hd6: y = 8'h4a; 8'hd7: y = 8'h0d;
      8'hd8: y = 8'h2d; 8'hd9: y = 8'he5; 8'hda: y = 8'h7a; 8'hdb: y = 8'h9f; 8'hdc: y = 8'h93; 8'hdd: y = 8'hc9; 8'hde: y = 8'h9c; 8'hdf: y = 8'hef;
      8'he0: y = 8'ha0; 8'he1: y = 8'he0; 8'he2: y = 8'h3b; 8'he3: y = 8'h4d; 8'he4: y = 8'hae; 8'he5: y = 8'h2a; 8'he6: y = 8'hf5; 8'he7: y = 8'hb0;
      8'he8: y = 8'hc8; 8'he9: y = 8'heb; 8'hea: y = 8'hbb; 8'heb: y = 8'h3c; 8'hec: y = 8'h83; 8'hed: y = 8'h53; 8'hee: y = 8'h99; 8'hef: y = 8'h61;
      8'hf0: y = 8'h17; 8'hf1: y = 8'h2b; 8'hf2: y = 8'h04; 8'hf3: y = 8'h7e; 8'hf4: y = 8'hba; 8'hf5: y = 8'h77; 8'hf6: y = 8'hd6; 8'hf7: y = 8'h26;
      8'hf8: y = 8'he1; 8'hf9: y = 8'h69; 8'hfa: y = 8'h14; 8'hfb: y = 8'h63; 8'hfc: y = 8'h55; 8'hfd: y = 8'h21; 8'hfe: y = 8'h0c; 8'hff: y = 8'h7d;
    endcase
    return y;
  endfunction

  logic [127:0] subbed_p0;
  logic [127:0] subbed_p1;
  logic         vld_p1;

  // Stage p0: sixteen independent byte lanes, purely combinational.
  for (genvar k = 0; k < 16; k++) begin : g_lane
    assign subbed_p0[8*k +: 8] = inv_sbox(input_block[8*k +: 8]);
  end

  // Stage p1: output register. Data holds when no new block is offered,
  // so a consumer that misses the valid cycle can still read the result.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      subbed_p1 <= 128'h0;
      vld_p1    <= 1'b0;
    end else begin
      vld_p1 <= in_valid;
      if (in_valid) begin
        subbed_p1 <= subbed_p0;
      end
    end
  end

  assign subbed_block = subbed_p1;
  assign out_valid    = vld_p1;

endmodule

// File: tb/tb_inv_sub_bytes.sv
module tb_inv_sub_bytes;

  logic         clk;
  logic         n_rst;
  logic         in_valid;
  logic [127:0] input_block;
  logic [127:0] subbed_block;
  logic         out_valid;

  int errors = 0;
  int checks = 0;

  logic [7:0] inv_tab [256];
  logic [7:0] fwd_tab [256];

  inv_sub_bytes dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .in_valid     (in_valid),
    .input_block  (input_block),
    .subbed_block (subbed_block),
    .out_valid    (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // GF(2^8) arithmetic modulo x^8+x^4+x^3+x+1
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
    end
    return p;
  endfunction

  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    r = 8'h00;
    if (a != 8'h00) begin
      for (int y = 1; y < 256; y++) begin
        if (gf_mul(a, 8'(y)) == 8'h01) r = 8'(y);
      end
    end
    return r;
  endfunction

  function automatic logic [7:0] inv_affine(input logic [7:0] x);
    logic [7:0] b;
    logic [7:0] d;
    d = 8'h05;
    for (int i = 0; i < 8; i++)
      b[i] = x[(i+2)%8] ^ x[(i+5)%8] ^ x[(i+7)%8] ^ d[i];
    return b;
  endfunction

  function automatic logic [7:0] fwd_affine(input logic [7:0] x);
    logic [7:0] b;
    logic [7:0] c;
    c = 8'h63;
    for (int i = 0; i < 8; i++)
      b[i] = x[i] ^ x[(i+4)%8] ^ x[(i+5)%8] ^ x[(i+6)%8] ^ x[(i+7)%8] ^ c[i];
    return b;
  endfunction

  function automatic logic [127:0] model_blk(input logic [127:0] blk);
    logic [127:0] r;
    for (int k = 0; k < 16; k++) r[8*k +: 8] = inv_tab[blk[8*k +: 8]];
    return r;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Offer one block, let the edge capture it, sample 1 time unit later.
  task automatic apply(input logic [127:0] blk);
    in_valid    = 1'b1;
    input_block = blk;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [127:0] a, b, c, blk, exp;
    logic [7:0]   ob;

    for (int x = 0; x < 256; x++) begin
      inv_tab[x] = gf_inv(inv_affine(8'(x)));
      fwd_tab[x] = fwd_affine(gf_inv(8'(x)));
    end

    // Reset asserted with an active input, before any clock edge
    n_rst       = 1'b0;
    in_valid    = 1'b1;
    input_block = {$urandom, $urandom, $urandom, $urandom};
    #2;
    check("reset_data_noclk", subbed_block, 128'h0);
    check("reset_vld_noclk", {127'h0, out_valid}, 128'h0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("reset_data_clk", subbed_block, 128'h0);
    check("reset_vld_clk", {127'h0, out_valid}, 128'h0);
    in_valid = 1'b0;
    @(negedge clk);
    n_rst = 1'b1;
    @(posedge clk); #1;
    check("post_reset_data", subbed_block, 128'h0);
    check("post_reset_vld", {127'h0, out_valid}, 128'h0);

    // Directed vectors
    apply(128'h2A34155C2FB5D8462C29FEC1B0579D6A);
    check("fips_vec", subbed_block, 128'h95282FA74ED22D98424C0CDDFCDA7558);
    check("fips_vld", {127'h0, out_valid}, 128'h1);
    apply({16{8'h00}});
    check("all_00", subbed_block, {16{8'h52}});
    apply({16{8'h63}});
    check("all_63", subbed_block, 128'h0);
    apply({16{8'hFF}});
    check("all_ff", subbed_block, {16{8'h7D}});
    apply({8'h01, 8'h7C, 8'h2A, 8'h34, 8'h15, 8'h5C, {10{8'h00}}});
    check("ref_entries", subbed_block, {8'h09, 8'h01, 8'h95, 8'h28, 8'h2F, 8'hA7, {10{8'h52}}});

    // Hold / valid behaviour
    a = {$urandom, $urandom, $urandom, $urandom};
    b = {$urandom, $urandom, $urandom, $urandom};
    c = {$urandom, $urandom, $urandom, $urandom};
    apply(a);
    check("hold_capture", subbed_block, model_blk(a));
    check("hold_capture_vld", {127'h0, out_valid}, 128'h1);
    for (int i = 0; i < 3; i++) begin
      input_block = {$urandom, $urandom, $urandom, $urandom};
      idle();
      check("hold_data", subbed_block, model_blk(a));
      check("hold_vld", {127'h0, out_valid}, 128'h0);
    end
    apply(a);
    check("b2b_a", subbed_block, model_blk(a));
    apply(b);
    check("b2b_b", subbed_block, model_blk(b));
    apply(c);
    check("b2b_c", subbed_block, model_blk(c));
    check("b2b_vld", {127'h0, out_valid}, 128'h1);

    // Randomized back-to-back stream
    for (int i = 0; i < 40; i++) begin
      blk = {$urandom, $urandom, $urandom, $urandom};
      apply(blk);
      check("random", subbed_block, model_blk(blk));
    end

    // Mid-stream reset between clock edges
    apply(a);
    apply(b);
    #2;
    n_rst = 1'b0;
    #1;
    check("midrst_data", subbed_block, 128'h0);
    check("midrst_vld", {127'h0, out_valid}, 128'h0);
    @(posedge clk); #1;
    check("midrst_hold_data", subbed_block, 128'h0);
    in_valid = 1'b0;
    #2;
    n_rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_release_data", subbed_block, 128'h0);
    check("midrst_release_vld", {127'h0, out_valid}, 128'h0);
    apply(c);
    check("midrst_resume", subbed_block, model_blk(c));

    // Exhaustive per-lane sweep plus S(InvS(x)) = x round trip
    for (int lane = 0; lane < 16; lane++) begin
      for (int v = 0; v < 256; v++) begin
        blk = 128'h0;
        blk[8*lane +: 8] = 8'(v);
        exp = {16{8'h52}};
        exp[8*lane +: 8] = inv_tab[v];
        apply(blk);
        check($sformatf("lane%0d_x%02h", lane, v), subbed_block, exp);
        ob = subbed_block[8*lane +: 8];
        check($sformatf("roundtrip%0d_x%02h", lane, v), {120'h0, fwd_tab[ob]}, {120'h0, 8'(v)});
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
